// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and the video/paddle datapath.
// The controller takes the slave side; the datapath (or a bench) takes the master side.
interface pong_game_ctrl_if;
  logic [1:0] btn_left;
  logic [1:0] btn_right;
  logic       hit;
  logic       miss;
  logic [9:0] x;
  logic [9:0] y;
  logic       gra_still;
  logic       game_over;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [1:0] balls_left;
  logic [1:0] state;

  modport master (
    output btn_left, btn_right, hit, miss, x, y,
    input  gra_still, game_over, score_ones, score_tens, balls_left, state
  );

  modport slave (
    input  btn_left, btn_right, hit, miss, x, y,
    output gra_still, game_over, score_ones, score_tens, balls_left, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new game / play / new ball / game over, with BCD score,
// ball count and a frame-tick driven delay timer.
module pong_game_ctrl #(
    parameter int unsigned BALLS        = 3,
    parameter int unsigned TIMER_FRAMES = 120,
    parameter int unsigned TICK_Y       = 481,
    parameter int unsigned TICK_X       = 0
) (
    input logic            clk,
    input logic            reset,
    pong_game_ctrl_if.slave bus
);

    localparam int unsigned TW_RAW = $clog2(TIMER_FRAMES + 1);
    localparam int unsigned TW     = (TW_RAW < 7) ? 7 : TW_RAW;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_FRAMES);
    localparam logic [1:0]    BALLS_INIT = 2'(BALLS);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    state_t        state_q, state_n;
    logic [3:0]    ones_q, ones_n, tens_q, tens_n;
    logic [1:0]    balls_q, balls_n;
    logic [TW-1:0] timer_q;
    logic          hit_d, miss_d;
    logic          hit_p, miss_p;
    logic          any_btn, frame_tick, timer_done, timer_start;

    assign any_btn    = (|bus.btn_left) | (|bus.btn_right);
    assign frame_tick = (bus.y == 10'(TICK_Y)) && (bus.x == 10'(TICK_X));
    assign hit_p      = bus.hit & ~hit_d;
    assign miss_p     = bus.miss & ~miss_d;
    assign timer_done = (timer_q == '0);

    always_comb begin
        state_n     = state_q;
        ones_n      = ones_q;
        tens_n      = tens_q;
        balls_n     = balls_q;
        timer_start = 1'b0;
        case (state_q)
            NEWGAME: begin
                ones_n  = '0;
                tens_n  = '0;
                balls_n = BALLS_INIT;
                if (any_btn) state_n = PLAY;
            end
            PLAY: begin
                // A miss wins over a simultaneous hit; that hit is dropped.
                if (miss_p) begin
                    timer_start = 1'b1;
                    if (balls_q <= 2'd1) begin
                        balls_n = '0;
                        state_n = OVER;
                    end else begin
                        balls_n = balls_q - 2'd1;
                        state_n = NEWBALL;
                    end
                end else if (hit_p && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
                    if (ones_q == 4'd9) begin
                        ones_n = '0;
                        tens_n = tens_q + 4'd1;
                    end else begin
                        ones_n = ones_q + 4'd1;
                    end
                end
            end
            NEWBALL: begin
                if (timer_done && any_btn) state_n = PLAY;
            end
            OVER: begin
                // Clear on the way out so NEWGAME shows a fresh scoreboard at once.
                if (timer_done) begin
                    state_n = NEWGAME;
                    ones_n  = '0;
                    tens_n  = '0;
                    balls_n = BALLS_INIT;
                end
            end
            default: state_n = NEWGAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NEWGAME;
            ones_q  <= '0;
            tens_q  <= '0;
            balls_q <= BALLS_INIT;
            timer_q <= '0;
            hit_d   <= 1'b0;
            miss_d  <= 1'b0;
        end else begin
            state_q <= state_n;
            ones_q  <= ones_n;
            tens_q  <= tens_n;
            balls_q <= balls_n;
            hit_d   <= bus.hit;
            miss_d  <= bus.miss;
            if (timer_start)
                timer_q <= TIMER_LOAD;
            else if (frame_tick && !timer_done)
                timer_q <= timer_q - TW'(1);
        end
    end

    assign bus.state      = state_q;
    assign bus.gra_still  = (state_q != PLAY);
    assign bus.game_over  = (state_q == OVER);
    assign bus.score_ones = ones_q;
    assign bus.score_tens = tens_q;
    assign bus.balls_left = balls_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a vector table for short sequences and
// hand-written sequences for the multi-cycle timer, saturation and priority cases.
module tb_pong_game_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .BALLS(3),
        .TIMER_FRAMES(120),
        .TICK_Y(481),
        .TICK_X(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] bl;
        logic [1:0] br;
        logic       hit;
        logic       miss;
        logic [1:0] st;
        logic [3:0] ones;
        logic [3:0] tens;
        logic [1:0] balls;
        logic       still;
        logic       over;
    } vec_t;

    vec_t vt [0:13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int ones, input int tens,
                             input int balls, input int still, input int over);
        check({tag, " state"}, int'(bus.state), st);
        check({tag, " ones"}, int'(bus.score_ones), ones);
        check({tag, " tens"}, int'(bus.score_tens), tens);
        check({tag, " balls"}, int'(bus.balls_left), balls);
        check({tag, " gra_still"}, int'(bus.gra_still), still);
        check({tag, " game_over"}, int'(bus.game_over), over);
    endtask

    task automatic hit_pulse();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        step();
    endtask

    task automatic tick();
        bus.y = 10'd481;
        step();
        bus.y = 10'd0;
        step();
    endtask

    initial begin
        reset         = 1'b0;
        bus.btn_left  = '0;
        bus.btn_right = '0;
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
        bus.x         = '0;
        bus.y         = '0;

        //          rst   bl     br     hit   miss  st     ones  tens  balls still over
        vt[0]  = '{1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 2'd3, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 2'd3, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd1, 4'd0, 4'd0, 2'd3, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 2'd1, 4'd0, 4'd0, 2'd3, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 4'd1, 4'd0, 2'd3, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 4'd1, 4'd0, 2'd3, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 4'd1, 4'd0, 2'd3, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 4'd1, 4'd0, 2'd3, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 4'd2, 4'd0, 2'd3, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 4'd2, 4'd0, 2'd3, 1'b0, 1'b0};
        vt[10] = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd2, 4'd0, 2'd2, 1'b1, 1'b0};
        vt[11] = '{1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 2'd2, 4'd2, 4'd0, 2'd2, 1'b1, 1'b0};
        vt[12] = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd2, 4'd2, 4'd0, 2'd2, 1'b1, 1'b0};
        vt[13] = '{1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 2'd3, 1'b1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            reset         = vt[i].rst;
            bus.btn_left  = vt[i].bl;
            bus.btn_right = vt[i].br;
            bus.hit       = vt[i].hit;
            bus.miss      = vt[i].miss;
            step();
            check_all($sformatf("vec%0d", i), int'(vt[i].st), int'(vt[i].ones), int'(vt[i].tens),
                      int'(vt[i].balls), int'(vt[i].still), int'(vt[i].over));
        end
        reset     = 1'b0;
        bus.hit   = 1'b0;
        bus.miss  = 1'b0;

        // Long-held hits count once each, then BCD carry and saturation.
        bus.btn_left = 2'd1;
        step();
        bus.btn_left = 2'd0;
        check_all("start", 1, 0, 0, 3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            bus.hit = 1'b1;
            repeat (50) step();
            bus.hit = 1'b0;
            step();
            check($sformatf("held_hit%0d ones", k), int'(bus.score_ones), k + 1);
        end
        repeat (6) hit_pulse();
        check_all("score09", 1, 9, 0, 3, 0, 0);
        hit_pulse();
        check_all("score10", 1, 0, 1, 3, 0, 0);
        repeat (89) hit_pulse();
        check_all("score99", 1, 9, 9, 3, 0, 0);
        hit_pulse();
        check_all("score99_sat", 1, 9, 9, 3, 0, 0);

        // First miss; button held through the whole delay.
        bus.miss = 1'b1;
        step();
        bus.miss = 1'b0;
        check_all("miss1", 2, 9, 9, 2, 1, 0);
        bus.btn_left = 2'd1;
        repeat (119) tick();
        check_all("nb_early_btn", 2, 9, 9, 2, 1, 0);
        bus.y = 10'd481;
        step();
        bus.y = 10'd0;
        check_all("nb_last_tick", 2, 9, 9, 2, 1, 0);
        step();
        check_all("nb_held_exit", 1, 9, 9, 2, 0, 0);
        bus.btn_left = 2'd0;

        // Second miss; delay expires with no button, then press.
        bus.miss = 1'b1;
        step();
        bus.miss = 1'b0;
        check_all("miss2", 2, 9, 9, 1, 1, 0);
        repeat (120) tick();
        check_all("nb_done_nobtn", 2, 9, 9, 1, 1, 0);
        bus.btn_right = 2'd1;
        step();
        bus.btn_right = 2'd0;
        check_all("nb_press_exit", 1, 9, 9, 1, 0, 0);

        // Last ball lost; buttons ignored during game over.
        bus.miss = 1'b1;
        step();
        bus.miss = 1'b0;
        check_all("miss3_over", 3, 9, 9, 0, 1, 1);
        bus.btn_left = 2'd3;
        repeat (119) tick();
        check_all("over_btn_ignored", 3, 9, 9, 0, 1, 1);
        bus.btn_left = 2'd0;
        bus.y = 10'd481;
        step();
        bus.y = 10'd0;
        check_all("over_last_tick", 3, 9, 9, 0, 1, 1);
        step();
        check("over_exit state", int'(bus.state), 0);
        step();
        check_all("newgame_clear", 0, 0, 0, 3, 1, 0);

        // Same-cycle hit and miss at score 05 with 2 balls.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.btn_left = 2'd1;
        step();
        bus.btn_left = 2'd0;
        repeat (5) hit_pulse();
        check_all("score05", 1, 5, 0, 3, 0, 0);
        bus.miss = 1'b1;
        step();
        bus.miss = 1'b0;
        repeat (120) tick();
        bus.btn_left = 2'd1;
        step();
        bus.btn_left = 2'd0;
        check_all("play_balls2", 1, 5, 0, 2, 0, 0);
        bus.hit  = 1'b1;
        bus.miss = 1'b1;
        step();
        bus.hit  = 1'b0;
        bus.miss = 1'b0;
        check_all("hit_miss_same", 2, 5, 0, 1, 1, 0);

        // Reset in the middle of the new-ball delay.
        repeat (10) tick();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all("reset_in_nb", 0, 0, 0, 3, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
